// File: rtl/vpu_lane_mem_resp_if.sv
// Lane-side bus between the multi-lane VPU (master) and the lane memory responder (slave).
// Per-lane fields are packed arrays indexed by lane number.
interface vpu_lane_mem_resp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int M      = 4
);
  logic                       vpu_done;
  logic [M-1:0]               mem_rdy;
  logic [M-1:0]               mem_read_en;
  logic [M-1:0]               mem_write_en;
  logic [M-1:0][ADDR_W-1:0]   addr_a;
  logic [M-1:0][ADDR_W-1:0]   addr_b;
  logic [M-1:0][ADDR_W-1:0]   addr_c;
  logic [M-1:0][DATA_W-1:0]   data_a;
  logic [M-1:0][DATA_W-1:0]   data_b;
  logic [M-1:0][DATA_W-1:0]   data_c;

  // Handshake: mem_rdy is a one-cycle launch pulse; mem_read_en marks data_a/data_b as valid
  // for the whole run; mem_write_en acknowledges a lane write in the same cycle addr_c/data_c
  // are presented; vpu_done is sampled once per cycle while the lanes run.
  modport master (
    output vpu_done, addr_a, addr_b, addr_c, data_c,
    input  mem_rdy, mem_read_en, mem_write_en, data_a, data_b
  );

  modport slave (
    input  vpu_done, addr_a, addr_b, addr_c, data_c,
    output mem_rdy, mem_read_en, mem_write_en, data_a, data_b
  );
endinterface

// File: rtl/vpu_lane_mem_resp.sv
// Lane memory responder: per-lane register banks serving A/B reads and C writes,
// a host preload/readback port, and the IDLE/START/RUN launch sequencer with timeout.
module vpu_lane_mem_resp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int M       = 4,
  parameter int DEPTH   = 32,
  parameter int LANE_W  = 2,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_go,
  input  logic                host_we,
  input  logic                host_re,
  input  logic [LANE_W-1:0]   host_lane,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_rvalid,
  output logic                host_ready,
  output logic                busy,
  output logic                timeout_err,
  output logic [1:0]          state_dbg,
  vpu_lane_mem_resp_if.slave  lane
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [LANE_W:0]   M_L      = (LANE_W+1)'(M);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                  state;
  logic [TMO_W-1:0]        tmo;
  logic [DATA_W-1:0]       bank [M][DEPTH];
  logic                    host_lane_ok;
  logic                    host_acc;

  // Word 0 is the null word: never written, so it always reads back as zero.
  function automatic logic addr_in(input logic [ADDR_W-1:0] a);
    return a < DEPTH_A;
  endfunction

  function automatic logic addr_wr(input logic [ADDR_W-1:0] a);
    return (a != '0) && (a < DEPTH_A);
  endfunction

  assign host_lane_ok = {1'b0, host_lane} < M_L;
  assign host_acc     = (state == IDLE);
  assign host_ready   = (state == IDLE);
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  always_comb begin
    lane.mem_write_en = '0;
    for (int i = 0; i < M; i++) begin
      lane.mem_write_en[i] = (state == RUN) && addr_wr(lane.addr_c[i]);
    end
  end

  // Host writes happen only in IDLE and lane writes only in RUN, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          bank[i][j] <= '0;
        end
      end
    end else begin
      if (host_acc && host_we && host_lane_ok && addr_wr(host_addr)) begin
        bank[host_lane][host_addr[IDX_W-1:0]] <= host_wdata;
      end
      for (int i = 0; i < M; i++) begin
        if (state == RUN && addr_wr(lane.addr_c[i])) begin
          bank[i][lane.addr_c[i][IDX_W-1:0]] <= lane.data_c[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane.data_a <= '0;
      lane.data_b <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        lane.data_a[i] <= addr_in(lane.addr_a[i]) ? bank[i][lane.addr_a[i][IDX_W-1:0]] : '0;
        lane.data_b[i] <= addr_in(lane.addr_b[i]) ? bank[i][lane.addr_b[i][IDX_W-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_acc && host_re;
      if (host_acc && host_re) begin
        host_rdata <= (host_lane_ok && addr_in(host_addr))
                      ? bank[host_lane][host_addr[IDX_W-1:0]] : '0;
      end
    end
  end

  // Completion is checked before the timeout so a done on the last cycle is not an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tmo              <= '0;
      lane.mem_rdy     <= '0;
      lane.mem_read_en <= '0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host_go) begin
            state        <= START;
            timeout_err  <= 1'b0;
            lane.mem_rdy <= '1;
          end
        end
        START: begin
          state            <= RUN;
          lane.mem_rdy     <= '0;
          lane.mem_read_en <= '1;
          tmo              <= '0;
        end
        RUN: begin
          if (lane.vpu_done) begin
            state            <= IDLE;
            lane.mem_read_en <= '0;
          end else if (tmo == TMO_LAST) begin
            state            <= IDLE;
            lane.mem_read_en <= '0;
            timeout_err      <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          state            <= IDLE;
          lane.mem_rdy     <= '0;
          lane.mem_read_en <= '0;
        end
      endcase
    end
  end

endmodule
